// File: rtl/dma_pkg.sv
// Shared DMA types: descriptor fields, queue entry payload and issue-sequencer states.
package dma_pkg;

    localparam int unsigned DESC_ADDR_W = 32;
    localparam int unsigned DESC_NUM_W  = 16;

    typedef logic [DESC_ADDR_W-1:0] desc_addr_t;
    typedef logic [DESC_NUM_W-1:0]  desc_num_t;

    typedef struct packed {
        desc_addr_t src;
        desc_addr_t dst;
        desc_num_t  len;
        logic       last;
    } dma_desc_t;

    typedef enum logic [1:0] {
        DQ_IDLE  = 2'd0,
        DQ_ISSUE = 2'd1,
        DQ_BUSY  = 2'd2
    } dq_state_e;

endpackage

// File: rtl/dma_desc_fifo.sv
// Synchronous descriptor FIFO with push/pop/flush; a push in a flush cycle lands after the flush.
module dma_desc_fifo
    import dma_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push_i,
    input  dma_desc_t                push_data_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output dma_desc_t                head_c,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [$clog2(DEPTH):0]   count_nxt_c
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    dma_desc_t        mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full;
    logic             push_ok;

    assign full        = (count_q == CNT_W'(DEPTH));
    assign push_ok     = push_i && !full;
    assign head_c      = mem_q[rd_ptr_q];
    assign count_o     = count_q;
    assign count_nxt_c = count_d;

    // Flush/pop first, then the accepted push on top of the result.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else if (pop_i && (count_q != '0)) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d  = count_q - CNT_W'(1);
        end
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            count_d  = count_d + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/dma_desc_queue.sv
// Descriptor queue and issue sequencer: buffers CSR pushes, issues one descriptor at a time
// to the transfer engine and raises the scheduler interrupt on last-done or error.
module dma_desc_queue
    import dma_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push_i,
    input  logic             push_last_i,
    input  desc_addr_t       push_src_i,
    input  desc_addr_t       push_dst_i,
    input  desc_num_t        push_len_i,
    input  logic             clear_irq_i,
    output logic             fifo_full_o,
    output logic             desc_valid_o,
    input  logic             desc_ready_i,
    output desc_addr_t       desc_src_o,
    output desc_addr_t       desc_dst_o,
    output desc_num_t        desc_len_o,
    input  logic             eng_done_i,
    input  logic             eng_err_i,
    output logic             irq_o,
    output logic             busy_o,
    output logic             drop_o,
    output logic [CNT_W-1:0] done_cnt_o
);

    localparam int unsigned FCNT_W = $clog2(DEPTH) + 1;

    dq_state_e         state_q, state_d;
    dma_desc_t         push_data;
    dma_desc_t         head_c;
    logic [FCNT_W-1:0] fcount;
    logic [FCNT_W-1:0] fcount_nxt_c;
    logic              pop;
    logic              flush;
    logic              irq_set;
    logic              done_inc;

    logic              cur_last_q, cur_last_d;
    logic              irq_q, irq_d;
    logic [CNT_W-1:0]  done_cnt_q, done_cnt_d;
    logic              valid_q, valid_d;
    desc_addr_t        src_q, src_d;
    desc_addr_t        dst_q, dst_d;
    desc_num_t         len_q, len_d;
    logic              full_q, full_d;
    logic              busy_q, busy_d;
    logic              drop_q, drop_d;

    assign push_data = '{src: push_src_i, dst: push_dst_i, len: push_len_i, last: push_last_i};

    dma_desc_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rstn        (rstn),
        .push_i      (push_i),
        .push_data_i (push_data),
        .pop_i       (pop),
        .flush_i     (flush),
        .head_c      (head_c),
        .count_o     (fcount),
        .count_nxt_c (fcount_nxt_c)
    );

    // Issue sequencer, interrupt and completion bookkeeping.
    always_comb begin
        state_d    = state_q;
        cur_last_d = cur_last_q;
        pop        = 1'b0;
        flush      = 1'b0;
        irq_set    = 1'b0;
        done_inc   = 1'b0;
        unique case (state_q)
            DQ_IDLE: begin
                if (fcount != '0) begin
                    state_d = DQ_ISSUE;
                end
            end
            DQ_ISSUE: begin
                if (desc_ready_i) begin
                    pop        = 1'b1;
                    cur_last_d = head_c.last;
                    state_d    = DQ_BUSY;
                end
            end
            DQ_BUSY: begin
                if (eng_err_i) begin
                    flush   = 1'b1;
                    irq_set = 1'b1;
                    state_d = DQ_IDLE;
                end else if (eng_done_i) begin
                    done_inc = 1'b1;
                    irq_set  = cur_last_q;
                    state_d  = DQ_IDLE;
                end
            end
            default: state_d = DQ_IDLE;
        endcase

        irq_d = irq_q;
        if (irq_set) begin
            irq_d = 1'b1;
        end else if (clear_irq_i) begin
            irq_d = 1'b0;
        end

        done_cnt_d = done_inc ? done_cnt_q + CNT_W'(1) : done_cnt_q;

        // Head stays put while offered, so loading it each ISSUE cycle keeps the outputs stable.
        valid_d = (state_d == DQ_ISSUE);
        src_d   = valid_d ? head_c.src : '0;
        dst_d   = valid_d ? head_c.dst : '0;
        len_d   = valid_d ? head_c.len : '0;

        full_d = (fcount_nxt_c == FCNT_W'(DEPTH));
        busy_d = (state_d != DQ_IDLE) || (fcount_nxt_c != '0);
        drop_d = push_i && full_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= DQ_IDLE;
            cur_last_q <= 1'b0;
            irq_q      <= 1'b0;
            done_cnt_q <= '0;
            valid_q    <= 1'b0;
            src_q      <= '0;
            dst_q      <= '0;
            len_q      <= '0;
            full_q     <= 1'b0;
            busy_q     <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_last_q <= cur_last_d;
            irq_q      <= irq_d;
            done_cnt_q <= done_cnt_d;
            valid_q    <= valid_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            len_q      <= len_d;
            full_q     <= full_d;
            busy_q     <= busy_d;
            drop_q     <= drop_d;
        end
    end

    assign fifo_full_o  = full_q;
    assign desc_valid_o = valid_q;
    assign desc_src_o   = src_q;
    assign desc_dst_o   = dst_q;
    assign desc_len_o   = len_q;
    assign irq_o        = irq_q;
    assign busy_o       = busy_q;
    assign drop_o       = drop_q;
    assign done_cnt_o   = done_cnt_q;

endmodule

// File: doc/dma_desc_queue.md
Name: dma_desc_queue

Overview:
Descriptor queue and issue sequencer between the DMA CSR control block and the DMA transfer engine. It captures each {src, dst, len, last} descriptor pushed by the CSR control logic into a small FIFO and issues descriptors one at a time to the engine over a valid/ready handshake. It tracks the in-flight descriptor, raises the L1 scheduler interrupt when a descriptor marked "last" completes or any transfer errors, and reports FIFO-full back to the CSR block.

Parameters:
DEPTH, 4, descriptor FIFO entries; power of two, >= 2
CNT_W, 16, width of completed-descriptor counter

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
push_i  in  1  single-cycle push strobe from CSR control (CFG[0] write)
push_last_i  in  1  descriptor is last of scatter list (CFG[1])
push_src_i  in  desc_addr_t  source address
push_dst_i  in  desc_addr_t  destination address
push_len_i  in  desc_num_t  transfer length
clear_irq_i  in  1  clear interrupt strobe (CFG[2])
fifo_full_o  out  1  FIFO holds DEPTH entries
desc_valid_o  out  1  descriptor offered to engine
desc_ready_i  in  1  engine accepts descriptor
desc_src_o  out  desc_addr_t  head source
desc_dst_o  out  desc_addr_t  head destination
desc_len_o  out  desc_num_t  head length
eng_done_i  in  1  engine finished in-flight descriptor (pulse)
eng_err_i  in  1  engine aborted in-flight descriptor (pulse)
irq_o  out  1  L1 scheduler interrupt, level, sticky
busy_o  out  1  descriptor in flight or queue non-empty
drop_o  out  1  one-cycle pulse: push dropped because FIFO full
done_cnt_o  out  CNT_W  completed descriptors, wraps at 2^CNT_W

Behaviour:
- Reset: all outputs 0, pointers/count 0, state IDLE. Reset mid-operation discards queue and in-flight state; no interrupt generated.
- Storage: DEPTH entries of {src, dst, len, last}; wr_ptr/rd_ptr log2(DEPTH) bits, wrap naturally; count is log2(DEPTH)+1 bits.
- fifo_full_o = (count == DEPTH), derived from registered count only.
- Push: when push_i && !fifo_full_o, write at wr_ptr on the clock edge. If push_i && fifo_full_o, the entry is dropped and drop_o pulses the next cycle. The push is dropped even if a pop occurs in the same cycle.
- Simultaneous push and pop (not full): count unchanged, both pointers advance.
- FSM states:
  - IDLE: desc_valid_o=0. If count != 0, go to ISSUE next cycle.
  - ISSUE: desc_valid_o=1; desc_*_o driven from the head entry, stable while stalled. On desc_valid_o && desc_ready_i: pop, latch cur_last = head.last, go to BUSY.
  - BUSY: desc_valid_o=0.
    - On eng_done_i: done_cnt_o += 1; if cur_last, set irq_o; go to IDLE.
    - On eng_err_i: flush FIFO (count=0, rd_ptr=wr_ptr), set irq_o, go to IDLE; done_cnt_o unchanged.
    - If eng_done_i and eng_err_i are asserted together, error wins.
- Latency: push at cycle N gives desc_valid_o at N+2 when idle and empty. Done at cycle M gives irq_o at M+1.
- A push in the same cycle as an error flush is accepted and survives: it is written after the flush.
- irq_o: set by last-done or error, cleared by clear_irq_i. Set has priority over a simultaneous clear.
- eng_done_i/eng_err_i outside BUSY are ignored.
- busy_o = (state != IDLE) || (count != 0).
- desc_*_o are 0 when desc_valid_o=0.

Decomposition:
- dma_pkg: descriptor entry struct dma_desc_t {src, dst, len, last}, FSM enum dq_state_e; desc_addr_t/desc_num_t already defined there.
- One sub-module: dma_desc_fifo, a generic synchronous FIFO of dma_desc_t with push/pop/flush and full/empty/count.
- The FSM, interrupt logic and counter live in the top.

Test Plan:
- Reset, then one push {src=0x1000, dst=0x2000, len=64, last=1} with ready=1 -> desc_valid_o at +2 with those values; eng_done_i -> irq_o=1, done_cnt_o=1; clear_irq_i -> irq_o=0.
- Push 4 descriptors with ready=0 -> fifo_full_o=1 after 4th; 5th push -> drop_o pulse, count stays 4; drain -> descriptors appear in push order, last=0 so irq_o stays 0.
- Three descriptors, last set only on 3rd, done after each -> irq_o rises only after 3rd done; done_cnt_o=3.
- Queue 3, eng_err_i on 1st in flight -> irq_o=1, FIFO empty, busy_o=0 next cycle, done_cnt_o=0; push in same cycle as err is retained and issued.
- clear_irq_i coincident with last-done -> irq_o=1; eng_done_i and eng_err_i together -> flush occurs.
- Assert rstn low while BUSY with 2 queued -> all outputs 0; a subsequent eng_done_i is ignored.
